// File: rtl/icache_arb_pkg.sv
// Shared types and constants for the ICACHE request-port arbiter.
package icache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RESP_READY = 2'd1,
    WAIT       = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    DMD  = 2'd1,
    PF   = 2'd2
  } owner_e;

  // Low address bits that select a byte inside a cache line (merge granularity).
  localparam int unsigned LINE_OFF = 4;
  // First address bit of the TLB virtual page number.
  localparam int unsigned VPN_LSB  = 12;

endpackage

// File: rtl/pf_age_counter.sv
// Saturating age counter for a prefetch that keeps losing arbitration.
// expire flags the last count before the prefetch must be discarded.
module pf_age_counter #(
  parameter int unsigned PF_TIMEOUT = 8,
  parameter int unsigned CNT_W      = (PF_TIMEOUT > 1) ? $clog2(PF_TIMEOUT) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PF_TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Count blocked cycles; clear wins over increment, and the count never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != LAST)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire = (count == LAST);

endmodule

// File: rtl/icache_port_arbiter.sv
// Arbitrates the single ICACHE/TLB request port between demand fetch and the
// next-line prefetcher. Demand has fixed priority, one request is in flight at
// a time, and the returned line is routed to its owner (or to both when a
// demand merged onto an in-flight prefetch of the same line).
module icache_port_arbiter
  import icache_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 40,
  parameter int unsigned IDX_W      = 12,
  parameter int unsigned LINE_W     = 128,
  parameter int unsigned PF_TIMEOUT = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CORE_lock,
  input  logic                      DMD_REQ_VALID,
  input  logic [ADDR_W-1:0]         DMD_REQ_ADDR,
  output logic                      DMD_REQ_READY,
  input  logic                      DMD_KILL,
  output logic                      DMD_RESP_VALID,
  output logic [LINE_W-1:0]         DMD_RESP_DATA,
  input  logic                      PF_REQ_VALID,
  input  logic [ADDR_W-1:0]         PF_REQ_ADDR,
  output logic                      PF_REQ_READY,
  output logic                      PF_DROP,
  output logic                      PF_RESP_VALID,
  output logic                      ICACHE_REQ_VALID,
  output logic [IDX_W-1:0]          ICACHE_REQ_BITS_IDX,
  output logic [ADDR_W-VPN_LSB-1:0] TLB_REQ_BITS_VPN,
  output logic                      ICACHE_REQ_BITS_KILL,
  output logic                      ICACHE_RESP_READY,
  input  logic                      ICACHE_RESP_VALID,
  input  logic [LINE_W-1:0]         ICACHE_RESP_BITS_DATABLOCK
);

  state_e              state;
  owner_e              owner;
  logic [ADDR_W-1:0]   addr_q;
  logic                merge_q;
  logic                dmd_pend_q;
  logic                pf_pend_q;

  logic                unlocked;
  logic [ADDR_W-1:0]   cur_addr;
  logic                dmd_grant;
  logic                pf_grant;
  logic                pf_blocked;
  logic                age_drop;
  logic                age_inc;
  logic                age_clr;
  logic                age_expire;
  logic                kill_dmd;
  logic                preempt;
  logic                merge_hit;
  logic                merge_clr;
  logic                resp_take;

  assign unlocked = ~CORE_lock;
  assign age_clr  = pf_grant | age_drop;

  pf_age_counter #(
    .PF_TIMEOUT (PF_TIMEOUT)
  ) u_pf_age (
    .clk    (CLK),
    .rst_n  (RST),
    .inc    (age_inc),
    .clr    (age_clr),
    .expire (age_expire)
  );

  // Per-state decisions: grants, aging, kill, preemption and merge detection.
  always_comb begin
    cur_addr   = addr_q;
    dmd_grant  = 1'b0;
    pf_grant   = 1'b0;
    pf_blocked = 1'b0;
    age_drop   = 1'b0;
    age_inc    = 1'b0;
    kill_dmd   = 1'b0;
    preempt    = 1'b0;
    merge_hit  = 1'b0;
    merge_clr  = 1'b0;
    resp_take  = 1'b0;
    if (RST) begin
      case (state)
        IDLE: begin
          cur_addr   = DMD_REQ_VALID ? DMD_REQ_ADDR : PF_REQ_ADDR;
          dmd_grant  = DMD_REQ_VALID & unlocked & ~DMD_KILL;
          pf_grant   = PF_REQ_VALID & ~DMD_REQ_VALID & unlocked & ~DMD_KILL;
          pf_blocked = PF_REQ_VALID & unlocked & ~pf_grant;
          age_drop   = pf_blocked & age_expire;
          age_inc    = pf_blocked & ~age_expire;
        end
        RESP_READY: begin
          kill_dmd = (owner == DMD) & DMD_KILL & unlocked;
          preempt  = (owner == PF) & DMD_REQ_VALID & unlocked;
        end
        WAIT: begin
          kill_dmd  = (owner == DMD) & DMD_KILL & unlocked;
          merge_hit = (owner == PF) & ~merge_q & DMD_REQ_VALID & ~DMD_KILL & unlocked &
                      (DMD_REQ_ADDR[ADDR_W-1:LINE_OFF] == addr_q[ADDR_W-1:LINE_OFF]);
          merge_clr = (owner == PF) & merge_q & DMD_KILL & unlocked;
          // The response is still captured while locked; a kill discards it.
          resp_take = ICACHE_RESP_VALID & ~kill_dmd;
        end
        default: ;
      endcase
    end
  end

  // Port-facing outputs; everything reads 0 while reset is asserted.
  always_comb begin
    ICACHE_REQ_VALID     = dmd_grant | pf_grant;
    DMD_REQ_READY        = dmd_grant | merge_hit;
    PF_REQ_READY         = pf_grant | age_drop;
    PF_DROP              = age_drop | preempt;
    ICACHE_REQ_BITS_KILL = kill_dmd | preempt;
    ICACHE_RESP_READY    = RST & (state == RESP_READY);
    ICACHE_REQ_BITS_IDX  = RST ? cur_addr[IDX_W-1:0] : '0;
    TLB_REQ_BITS_VPN     = RST ? cur_addr[ADDR_W-1:VPN_LSB] : '0;
    // Response pulses come from registered flags and are held off while the
    // core is locked, so they appear in the first unlocked cycle.
    DMD_RESP_VALID       = RST & unlocked & dmd_pend_q;
    PF_RESP_VALID        = RST & unlocked & pf_pend_q;
  end

  // Arbiter FSM: owner/address latch, merge flag and response registers.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state         <= IDLE;
      owner         <= NONE;
      addr_q        <= '0;
      merge_q       <= 1'b0;
      dmd_pend_q    <= 1'b0;
      pf_pend_q     <= 1'b0;
      DMD_RESP_DATA <= '0;
    end else begin
      if (unlocked) begin
        dmd_pend_q <= 1'b0;
        pf_pend_q  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (dmd_grant | pf_grant) begin
            state   <= RESP_READY;
            addr_q  <= cur_addr;
            merge_q <= 1'b0;
            if (dmd_grant) owner <= DMD;
            else           owner <= PF;
          end
        end
        RESP_READY: begin
          if (kill_dmd | preempt) begin
            state <= IDLE;
            owner <= NONE;
          end else if (unlocked) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (kill_dmd) begin
            state   <= IDLE;
            owner   <= NONE;
            merge_q <= 1'b0;
          end else if (resp_take) begin
            DMD_RESP_DATA <= ICACHE_RESP_BITS_DATABLOCK;
            // A merge detected in this very cycle still shares the line.
            dmd_pend_q    <= (owner == DMD) | (merge_q & ~merge_clr) | merge_hit;
            pf_pend_q     <= (owner == PF);
            state         <= IDLE;
            owner         <= NONE;
            merge_q       <= 1'b0;
          end else if (merge_hit) begin
            merge_q <= 1'b1;
          end else if (merge_clr) begin
            merge_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          owner <= NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_port_arbiter.sv
// Self-checking bench for icache_port_arbiter: directed scenarios followed by
// randomized traffic, every cycle compared against a transaction-level model.
module tb_icache_port_arbiter;

  localparam int unsigned ADDR_W     = 40;
  localparam int unsigned IDX_W      = 12;
  localparam int unsigned LINE_W     = 128;
  localparam int unsigned PF_TIMEOUT = 8;

  logic                CLK = 1'b0;
  logic                RST = 1'b0;
  logic                CORE_lock = 1'b0;
  logic                DMD_REQ_VALID = 1'b0;
  logic [ADDR_W-1:0]   DMD_REQ_ADDR = '0;
  logic                DMD_REQ_READY;
  logic                DMD_KILL = 1'b0;
  logic                DMD_RESP_VALID;
  logic [LINE_W-1:0]   DMD_RESP_DATA;
  logic                PF_REQ_VALID = 1'b0;
  logic [ADDR_W-1:0]   PF_REQ_ADDR = '0;
  logic                PF_REQ_READY;
  logic                PF_DROP;
  logic                PF_RESP_VALID;
  logic                ICACHE_REQ_VALID;
  logic [IDX_W-1:0]    ICACHE_REQ_BITS_IDX;
  logic [ADDR_W-13:0]  TLB_REQ_BITS_VPN;
  logic                ICACHE_REQ_BITS_KILL;
  logic                ICACHE_RESP_READY;
  logic                ICACHE_RESP_VALID = 1'b0;
  logic [LINE_W-1:0]   ICACHE_RESP_BITS_DATABLOCK = '0;

  always #5 CLK = ~CLK;

  icache_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .IDX_W      (IDX_W),
    .LINE_W     (LINE_W),
    .PF_TIMEOUT (PF_TIMEOUT)
  ) dut (
    .CLK                        (CLK),
    .RST                        (RST),
    .CORE_lock                  (CORE_lock),
    .DMD_REQ_VALID              (DMD_REQ_VALID),
    .DMD_REQ_ADDR               (DMD_REQ_ADDR),
    .DMD_REQ_READY              (DMD_REQ_READY),
    .DMD_KILL                   (DMD_KILL),
    .DMD_RESP_VALID             (DMD_RESP_VALID),
    .DMD_RESP_DATA              (DMD_RESP_DATA),
    .PF_REQ_VALID               (PF_REQ_VALID),
    .PF_REQ_ADDR                (PF_REQ_ADDR),
    .PF_REQ_READY               (PF_REQ_READY),
    .PF_DROP                    (PF_DROP),
    .PF_RESP_VALID              (PF_RESP_VALID),
    .ICACHE_REQ_VALID           (ICACHE_REQ_VALID),
    .ICACHE_REQ_BITS_IDX        (ICACHE_REQ_BITS_IDX),
    .TLB_REQ_BITS_VPN           (TLB_REQ_BITS_VPN),
    .ICACHE_REQ_BITS_KILL       (ICACHE_REQ_BITS_KILL),
    .ICACHE_RESP_READY          (ICACHE_RESP_READY),
    .ICACHE_RESP_VALID          (ICACHE_RESP_VALID),
    .ICACHE_RESP_BITS_DATABLOCK (ICACHE_RESP_BITS_DATABLOCK)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, want %0h", tag, $time, got, want);
    end
  endtask

  // Transaction-level reference: the request in flight, its handshake
  // progress, the prefetch wait age and the line waiting to be returned.
  bit           m_busy, m_shaken, m_is_pf, m_merged, m_pend_d, m_pend_p;
  logic [39:0]  m_addr;
  int unsigned  m_age;
  logic [127:0] m_line;

  // Snapshot of the DUT outputs from the most recent step.
  logic         o_dmd_ready, o_pf_ready, o_drop, o_kill, o_req_valid, o_dmd_rv, o_pf_rv;
  logic [11:0]  o_idx;
  logic [27:0]  o_vpn;
  logic [127:0] o_data;

  task automatic model_reset();
    m_busy = 0; m_shaken = 0; m_is_pf = 0; m_merged = 0;
    m_pend_d = 0; m_pend_p = 0; m_addr = '0; m_age = 0; m_line = '0;
  endtask

  // One clock cycle: inputs are already driven; sample, compare, advance model.
  task automatic step();
    bit unl, g_d, g_p, drop_age, kill_hit, preempt, mhit, mclr;
    bit e_req, e_dr, e_pr, e_drop, e_kill, e_rr, e_dv, e_pv;
    logic [39:0]  sel;
    logic [127:0] e_data;
    #2;
    o_dmd_ready = DMD_REQ_READY;  o_pf_ready = PF_REQ_READY;  o_drop = PF_DROP;
    o_kill = ICACHE_REQ_BITS_KILL; o_req_valid = ICACHE_REQ_VALID;
    o_dmd_rv = DMD_RESP_VALID;    o_pf_rv = PF_RESP_VALID;    o_data = DMD_RESP_DATA;
    o_idx = ICACHE_REQ_BITS_IDX;  o_vpn = TLB_REQ_BITS_VPN;

    unl = !CORE_lock;
    g_d = 0; g_p = 0; drop_age = 0; kill_hit = 0; preempt = 0; mhit = 0; mclr = 0;
    e_req = 0; e_dr = 0; e_pr = 0; e_drop = 0; e_kill = 0; e_rr = 0; e_dv = 0; e_pv = 0;
    sel = '0;
    e_data = m_line;
    if (RST) begin
      e_dv = m_pend_d && unl;
      e_pv = m_pend_p && unl;
      if (!m_busy) begin
        sel      = DMD_REQ_VALID ? DMD_REQ_ADDR : PF_REQ_ADDR;
        g_d      = DMD_REQ_VALID && unl && !DMD_KILL;
        g_p      = PF_REQ_VALID && !DMD_REQ_VALID && unl && !DMD_KILL;
        drop_age = PF_REQ_VALID && unl && !g_p && (m_age == PF_TIMEOUT - 1);
        e_req = g_d || g_p; e_dr = g_d; e_pr = g_p || drop_age; e_drop = drop_age;
      end else if (!m_shaken) begin
        sel = m_addr; e_rr = 1;
        kill_hit = unl && !m_is_pf && DMD_KILL;
        preempt  = unl && m_is_pf && DMD_REQ_VALID;
        e_kill = kill_hit || preempt; e_drop = preempt;
      end else begin
        sel = m_addr;
        kill_hit = unl && !m_is_pf && DMD_KILL;
        mhit = unl && m_is_pf && !m_merged && DMD_REQ_VALID && !DMD_KILL &&
               (DMD_REQ_ADDR[39:4] == m_addr[39:4]);
        mclr = unl && m_is_pf && m_merged && DMD_KILL;
        e_kill = kill_hit; e_dr = mhit;
      end
    end

    check_eq("req_valid",  128'(o_req_valid),       128'(e_req));
    check_eq("dmd_ready",  128'(o_dmd_ready),       128'(e_dr));
    check_eq("pf_ready",   128'(o_pf_ready),        128'(e_pr));
    check_eq("pf_drop",    128'(o_drop),            128'(e_drop));
    check_eq("req_kill",   128'(o_kill),            128'(e_kill));
    check_eq("resp_ready", 128'(ICACHE_RESP_READY), 128'(e_rr));
    check_eq("idx",        128'(o_idx),             128'(sel[11:0]));
    check_eq("vpn",        128'(o_vpn),             128'(sel[39:12]));
    check_eq("dmd_rv",     128'(o_dmd_rv),          128'(e_dv));
    check_eq("pf_rv",      128'(o_pf_rv),           128'(e_pv));
    check_eq("dmd_data",   o_data,                  e_data);

    if (!RST) begin
      model_reset();
    end else begin
      if (unl) begin m_pend_d = 0; m_pend_p = 0; end
      if (!m_busy) begin
        if (g_d || g_p) begin
          m_busy = 1; m_shaken = 0; m_is_pf = g_p; m_addr = sel; m_merged = 0;
        end
        if (g_p || drop_age) m_age = 0;
        else if (PF_REQ_VALID && unl && m_age < PF_TIMEOUT - 1) m_age++;
      end else if (!m_shaken) begin
        if (kill_hit || preempt) m_busy = 0;
        else if (unl) m_shaken = 1;
      end else begin
        if (kill_hit) m_busy = 0;
        else if (ICACHE_RESP_VALID) begin
          m_line   = ICACHE_RESP_BITS_DATABLOCK;
          m_pend_d = !m_is_pf || (m_merged && !mclr) || mhit;
          m_pend_p = m_is_pf;
          m_busy   = 0;
        end else begin
          m_merged = (m_merged || mhit) && !mclr;
        end
      end
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle_in();
    RST = 1'b1; CORE_lock = 1'b0; DMD_KILL = 1'b0;
    DMD_REQ_VALID = 1'b0; DMD_REQ_ADDR = '0;
    PF_REQ_VALID = 1'b0; PF_REQ_ADDR = '0;
    ICACHE_RESP_VALID = 1'b0; ICACHE_RESP_BITS_DATABLOCK = '0;
  endtask

  task automatic quiet(input int unsigned n);
    idle_in();
    repeat (n) step();
  endtask

  function automatic logic [39:0] rand_addr();
    logic [39:0] a;
    case ($urandom_range(0, 3))
      0:       a = 40'h00_8000_0010;
      1:       a = 40'h00_0000_1040;
      2:       a = 40'hFF_FFFF_F000;
      default: a = {8'($urandom), 32'($urandom)};
    endcase
    a[5:0] = a[5:0] ^ 6'($urandom_range(0, 63));
    return a;
  endfunction

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [127:0] d1, d2;

  initial begin
    model_reset();
    @(posedge CLK);
    @(negedge CLK);

    // Reset with noisy inputs: everything must read 0.
    RST = 1'b0; DMD_REQ_VALID = 1'b1; PF_REQ_VALID = 1'b1; ICACHE_RESP_VALID = 1'b1;
    DMD_REQ_ADDR = 40'h12_3456_789A;
    step();
    check_eq("rst_req_valid", 128'(o_req_valid), 128'(0));
    check_eq("rst_dmd_ready", 128'(o_dmd_ready), 128'(0));
    step();
    quiet(1);

    // Demand 0x80000010, line returned on cycle 2, delivered on cycle 3.
    d1 = rand_line();
    DMD_REQ_VALID = 1'b1; DMD_REQ_ADDR = 40'h00_8000_0010;
    step();
    check_eq("s1_grant", 128'(o_dmd_ready), 128'(1));
    check_eq("s1_idx",   128'(o_idx),       128'(12'h010));
    check_eq("s1_vpn",   128'(o_vpn),       128'(28'h0080000));
    DMD_REQ_VALID = 1'b0;
    step();
    ICACHE_RESP_VALID = 1'b1; ICACHE_RESP_BITS_DATABLOCK = d1;
    step();
    check_eq("s1_early_rv", 128'(o_dmd_rv), 128'(0));
    ICACHE_RESP_VALID = 1'b0;
    step();
    check_eq("s1_rv",   128'(o_dmd_rv), 128'(1));
    check_eq("s1_data", o_data,         d1);
    quiet(1);

    // Demand and prefetch together: demand first, prefetch in the next IDLE.
    DMD_REQ_VALID = 1'b1; DMD_REQ_ADDR = 40'h00_0000_2000;
    PF_REQ_VALID  = 1'b1; PF_REQ_ADDR  = 40'h00_0000_2040;
    step();
    check_eq("s2_dmd_ready", 128'(o_dmd_ready), 128'(1));
    check_eq("s2_pf_ready",  128'(o_pf_ready),  128'(0));
    DMD_REQ_VALID = 1'b0;
    step();
    ICACHE_RESP_VALID = 1'b1; ICACHE_RESP_BITS_DATABLOCK = rand_line();
    step();
    ICACHE_RESP_VALID = 1'b0;
    step();
    check_eq("s2_pf_grant", 128'(o_pf_ready), 128'(1));
    PF_REQ_VALID = 1'b0;
    step();
    ICACHE_RESP_VALID = 1'b1;
    step();
    quiet(2);

    // Kill on the same cycle as the returning line: data discarded.
    DMD_REQ_VALID = 1'b1; DMD_REQ_ADDR = 40'h00_0000_5000;
    step();
    DMD_REQ_VALID = 1'b0;
    step();
    DMD_KILL = 1'b1; ICACHE_RESP_VALID = 1'b1; ICACHE_RESP_BITS_DATABLOCK = rand_line();
    step();
    check_eq("s3_kill", 128'(o_kill), 128'(1));
    DMD_KILL = 1'b0; ICACHE_RESP_VALID = 1'b0;
    DMD_REQ_VALID = 1'b1; DMD_REQ_ADDR = 40'h00_0000_6000;
    step();
    check_eq("s3_no_rv",     128'(o_dmd_rv),    128'(0));
    check_eq("s3_idle_gnt",  128'(o_dmd_ready), 128'(1));
    DMD_REQ_VALID = 1'b0;
    step();
    ICACHE_RESP_VALID = 1'b1;
    step();
    quiet(2);

    // Demand arriving while a prefetch is in RESP_READY preempts it.
    PF_REQ_VALID = 1'b1; PF_REQ_ADDR = 40'h00_0000_3000;
    step();
    check_eq("s4_pf_grant", 128'(o_pf_ready), 128'(1));
    PF_REQ_VALID = 1'b0; DMD_REQ_VALID = 1'b1; DMD_REQ_ADDR = 40'h00_0000_4000;
    step();
    check_eq("s4_kill",  128'(o_kill),      128'(1));
    check_eq("s4_drop",  128'(o_drop),      128'(1));
    check_eq("s4_no_dr", 128'(o_dmd_ready), 128'(0));
    step();
    check_eq("s4_dmd_grant", 128'(o_dmd_ready), 128'(1));
    DMD_REQ_VALID = 1'b0;
    step();
    ICACHE_RESP_VALID = 1'b1;
    step();
    quiet(2);

    // Demand to the same line as a waiting prefetch merges onto it.
    d2 = rand_line();
    PF_REQ_VALID = 1'b1; PF_REQ_ADDR = 40'h00_0000_1040;
    step();
    PF_REQ_VALID = 1'b0;
    step();
    DMD_REQ_VALID = 1'b1; DMD_REQ_ADDR = 40'h00_0000_1048;
    step();
    check_eq("s5_merge", 128'(o_dmd_ready), 128'(1));
    DMD_REQ_VALID = 1'b0; ICACHE_RESP_VALID = 1'b1; ICACHE_RESP_BITS_DATABLOCK = d2;
    step();
    ICACHE_RESP_VALID = 1'b0;
    step();
    check_eq("s5_dmd_rv", 128'(o_dmd_rv), 128'(1));
    check_eq("s5_pf_rv",  128'(o_pf_rv),  128'(1));
    check_eq("s5_data",   o_data,         d2);
    quiet(1);

    // Prefetch starved by back-to-back demands: dropped on its 8th blocked IDLE.
    for (int k = 0; k < 10; k++) begin
      DMD_REQ_VALID = 1'b1; DMD_REQ_ADDR = 40'h00_0001_0000 + 40'(k * 16);
      PF_REQ_VALID = 1'b1; PF_REQ_ADDR = 40'h00_0000_9000; ICACHE_RESP_VALID = 1'b0;
      step();
      check_eq("s6_drop",     128'(o_drop),     128'(k == 7));
      check_eq("s6_pf_ready", 128'(o_pf_ready), 128'(k == 7));
      DMD_REQ_VALID = 1'b0;
      step();
      ICACHE_RESP_VALID = 1'b1;
      step();
    end
    quiet(2);

    // Randomized traffic with locks, kills and occasional resets.
    for (int i = 0; i < 2500; i++) begin
      RST               = ($urandom_range(0, 299) != 0);
      CORE_lock         = ($urandom_range(0, 9) == 0);
      DMD_KILL          = ($urandom_range(0, 11) == 0);
      DMD_REQ_VALID     = ($urandom_range(0, 9) < 4);
      DMD_REQ_ADDR      = rand_addr();
      PF_REQ_VALID      = ($urandom_range(0, 9) < 5);
      PF_REQ_ADDR       = rand_addr();
      ICACHE_RESP_VALID = ($urandom_range(0, 9) < 4);
      ICACHE_RESP_BITS_DATABLOCK = rand_line();
      step();
    end
    quiet(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
